// File: rtl/fpu_issue_arbiter.sv
// Round-robin issue of EX-stage and matmul-sequencer ops onto one shared
// multi-cycle FPU, with a done watchdog and a one-hot response pulse.
module fpu_issue_arbiter #(
   parameter int XLEN    = 32,
   parameter int CTRL_W  = 3,
   parameter int TAG_W   = 5,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [CTRL_W-1:0] req0_ctrl,
   input  logic [XLEN-1:0]   req0_a,
   input  logic [XLEN-1:0]   req0_b,
   input  logic [TAG_W-1:0]  req0_tag,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [CTRL_W-1:0] req1_ctrl,
   input  logic [XLEN-1:0]   req1_a,
   input  logic [XLEN-1:0]   req1_b,
   input  logic [TAG_W-1:0]  req1_tag,
   output logic              fpu_start,
   output logic [CTRL_W-1:0] fpu_ctrl,
   output logic [XLEN-1:0]   fpu_a,
   output logic [XLEN-1:0]   fpu_b,
   input  logic              fpu_done,
   input  logic [XLEN-1:0]   fpu_result,
   input  logic [4:0]        fpu_flags,
   output logic [1:0]        rsp_valid,
   output logic [XLEN-1:0]   rsp_result,
   output logic [4:0]        rsp_flags,
   output logic [TAG_W-1:0]  rsp_tag,
   output logic              rsp_timeout,
   output logic              busy
);

   localparam int CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [XLEN-1:0]  QNAN     = XLEN'(32'h7FC0_0000);
   localparam logic [4:0]       NV_FLAG  = 5'b10000;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t             state;
   logic               last_grant;
   logic               grant_q;
   logic [CNT_W-1:0]   cnt;
   logic [TAG_W-1:0]   tag_q;
   logic               any_v;
   logic               pick;
   logic               accept;

   // Round-robin pick; a tie goes to the port that did not win last time.
   always_comb begin
      any_v      = req0_valid | req1_valid;
      pick       = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
      accept     = (state == IDLE) & any_v;
      req0_ready = accept & ~pick;
      req1_ready = accept & pick;
   end

   // Issue sequencer: latch, start pulse, watchdog wait, one-cycle response.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         last_grant  <= 1'b1;
         grant_q     <= 1'b0;
         cnt         <= '0;
         tag_q       <= '0;
         fpu_start   <= 1'b0;
         fpu_ctrl    <= '0;
         fpu_a       <= '0;
         fpu_b       <= '0;
         rsp_valid   <= '0;
         rsp_result  <= '0;
         rsp_flags   <= '0;
         rsp_tag     <= '0;
         rsp_timeout <= 1'b0;
         busy        <= 1'b0;
      end else begin
         fpu_start   <= 1'b0;
         rsp_valid   <= '0;
         rsp_timeout <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  fpu_ctrl   <= pick ? req1_ctrl : req0_ctrl;
                  fpu_a      <= pick ? req1_a : req0_a;
                  fpu_b      <= pick ? req1_b : req0_b;
                  tag_q      <= pick ? req1_tag : req0_tag;
                  grant_q    <= pick;
                  last_grant <= pick;
                  fpu_start  <= 1'b1;
                  busy       <= 1'b1;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               cnt   <= '0;
               state <= WAIT;
            end
            WAIT: begin
               if (fpu_done) begin
                  rsp_result <= fpu_result;
                  rsp_flags  <= fpu_flags;
                  rsp_tag    <= tag_q;
                  rsp_valid  <= grant_q ? 2'b10 : 2'b01;
                  state      <= RESP;
               end else if (cnt == CNT_LAST) begin
                  rsp_result  <= QNAN;
                  rsp_flags   <= NV_FLAG;
                  rsp_tag     <= tag_q;
                  rsp_timeout <= 1'b1;
                  rsp_valid   <= grant_q ? 2'b10 : 2'b01;
                  state       <= RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Randomized bench for fpu_issue_arbiter: cycle-level reference model
// predicts grants and responses; a monitor checks responses from a queue.
module tb_fpu_issue_arbiter;

   localparam int TO   = 64;
   localparam int NCYC = 4000;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [2:0]  req0_ctrl, req1_ctrl;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [4:0]  req0_tag, req1_tag;
   logic        fpu_start;
   logic [2:0]  fpu_ctrl;
   logic [31:0] fpu_a, fpu_b;
   logic        fpu_done;
   logic [31:0] fpu_result;
   logic [4:0]  fpu_flags;
   logic [1:0]  rsp_valid;
   logic [31:0] rsp_result;
   logic [4:0]  rsp_flags;
   logic [4:0]  rsp_tag;
   logic        rsp_timeout;
   logic        busy;

   fpu_issue_arbiter #(
      .XLEN(32), .CTRL_W(3), .TAG_W(5), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_ctrl(req0_ctrl), .req0_a(req0_a), .req0_b(req0_b),
      .req0_tag(req0_tag),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_ctrl(req1_ctrl), .req1_a(req1_a), .req1_b(req1_b),
      .req1_tag(req1_tag),
      .fpu_start(fpu_start), .fpu_ctrl(fpu_ctrl),
      .fpu_a(fpu_a), .fpu_b(fpu_b),
      .fpu_done(fpu_done), .fpu_result(fpu_result),
      .fpu_flags(fpu_flags),
      .rsp_valid(rsp_valid), .rsp_result(rsp_result),
      .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
      .rsp_timeout(rsp_timeout), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [1:0]  v;
      logic [4:0]  tag;
      logic [31:0] res;
      logic [4:0]  fl;
      logic        to;
   } exp_t;

   exp_t q[$];

   int checks = 0;
   int failures = 0;

   // requester payloads held until accepted
   bit          pv[2];
   logic [2:0]  pc[2];
   logic [31:0] pa[2], pb[2];
   logic [4:0]  pt[2];

   // reference model state
   bit          lg;
   int          free_at, start_cyc, resp_cyc, done_cyc;
   logic [2:0]  ic;
   logic [31:0] ia, ib;
   logic [31:0] dres;
   logic [4:0]  dfl;

   task automatic check(input string name, input logic [127:0] act,
                        input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at cycle %0d",
                  name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] fres(input logic [2:0] c,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
      return (a ^ {b[15:0], b[31:16]}) + {29'd0, c};
   endfunction

   function automatic logic [4:0] ffl(input logic [2:0] c,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
      return a[4:0] ^ b[4:0] ^ {2'b00, c};
   endfunction

   task automatic new_op(input int p);
      pv[p] = 1'b1;
      pc[p] = 3'($urandom_range(0, 7));
      pa[p] = $urandom;
      pb[p] = $urandom;
      pt[p] = 5'($urandom_range(0, 31));
   endtask

   task automatic drive_reqs();
      req0_valid = pv[0];
      req0_ctrl  = pc[0];
      req0_a     = pa[0];
      req0_b     = pb[0];
      req0_tag   = pt[0];
      req1_valid = pv[1];
      req1_ctrl  = pc[1];
      req1_a     = pa[1];
      req1_b     = pb[1];
      req1_tag   = pt[1];
   endtask

   task automatic check_reset_outputs();
      check("rst_start", 128'(fpu_start), 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
      check("rst_rsp_timeout", 128'(rsp_timeout), 128'(0));
      check("rst_fpu_ops", 128'({fpu_ctrl, fpu_a, fpu_b}), 128'(0));
      check("rst_rsp_data",
            128'({rsp_result, rsp_flags, rsp_tag}), 128'(0));
   endtask

   // monitor: every response pulse is matched against the queue head
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rsp_valid !== 2'b00) begin
            if (q.size() == 0) begin
               check("unexpected_rsp", 128'(rsp_valid), 128'(0));
            end else begin
               e = q.pop_front();
               check("rsp", 128'({32'(cyc), rsp_valid, rsp_tag,
                                  rsp_result, rsp_flags, rsp_timeout}),
                     128'({32'(e.cyc), e.v, e.tag,
                           e.res, e.fl, e.to}));
            end
         end else begin
            check("timeout_idle", 128'(rsp_timeout), 128'(0));
         end
      end
   end

   // driver and reference model, one iteration per clock cycle
   initial begin
      int     c, d, p;
      bit     gen, inflight, rst_done, skip_neg;
      logic [1:0] exp_r;
      exp_t   e;

      reset = 1'b0;
      pv[0] = 1'b0;
      pv[1] = 1'b0;
      pc[0] = '0; pc[1] = '0;
      pa[0] = '0; pa[1] = '0;
      pb[0] = '0; pb[1] = '0;
      pt[0] = '0; pt[1] = '0;
      drive_reqs();
      fpu_done   = 1'b0;
      fpu_result = '0;
      fpu_flags  = '0;
      lg        = 1'b1;
      start_cyc = -10;
      resp_cyc  = -10;
      done_cyc  = -10;
      rst_done  = 1'b0;
      ic = '0; ia = '0; ib = '0;

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();
      @(negedge clk);
      reset   = 1'b1;
      free_at = cyc;

      for (int k = 0; k < NCYC; k++) begin
         @(posedge clk);
         #1;
         c   = cyc;
         gen = (k < NCYC - 150);
         for (int i = 0; i < 2; i++)
            if (gen && !pv[i] && $urandom_range(0, 99) < 70)
               new_op(i);
         drive_reqs();

         inflight = (c >= start_cyc) && (c <= resp_cyc);
         fpu_done = 1'b0;
         if (inflight && c == done_cyc) begin
            fpu_done   = 1'b1;
            fpu_result = dres;
            fpu_flags  = dfl;
         end else if (!inflight || c == start_cyc || c == resp_cyc) begin
            fpu_done   = ($urandom_range(0, 99) < 15) || (c == done_cyc);
            fpu_result = $urandom;
            fpu_flags  = 5'($urandom);
         end else begin
            fpu_result = $urandom;
         end

         skip_neg = 1'b0;
         if (!rst_done && k > 1500 &&
             c > start_cyc + 1 && c + 3 < resp_cyc) begin
            #2;
            reset = 1'b0;
            #1;
            check_reset_outputs();
            rst_done = 1'b1;
            for (int i = 0; i < 2; i++)
               if (!pv[i]) new_op(i);
            drive_reqs();
            q.delete();
            start_cyc  = -10;
            resp_cyc   = -10;
            lg         = 1'b1;
            fpu_done   = 1'b1;
            fpu_result = $urandom;
            @(negedge clk);
            reset    = 1'b1;
            free_at  = c;
            skip_neg = 1'b1;
         end
         if (!skip_neg) @(negedge clk);

         inflight = (c >= start_cyc) && (c <= resp_cyc);
         exp_r = 2'b00;
         if (c >= free_at && (pv[0] || pv[1])) begin
            if (pv[0] && pv[1]) p = lg ? 0 : 1;
            else p = pv[1] ? 1 : 0;
            exp_r = (p == 1) ? 2'b10 : 2'b01;
         end
         check("ready", 128'({req1_ready, req0_ready}), 128'(exp_r));
         check("start", 128'(fpu_start), 128'(c == start_cyc));
         check("busy", 128'(busy), 128'(inflight));
         if (c == start_cyc)
            check("fpu_operands", 128'({fpu_ctrl, fpu_a, fpu_b}),
                  128'({ic, ia, ib}));

         if (exp_r != 2'b00) begin
            p     = exp_r[1] ? 1 : 0;
            pv[p] = 1'b0;
            lg    = p[0];
            ic    = pc[p];
            ia    = pa[p];
            ib    = pb[p];
            d = $urandom_range(0, 9);
            if (d == 0) d = 0;
            else if (d == 1) d = TO;
            else d = $urandom_range(1, 6);
            start_cyc = c + 1;
            e.v   = exp_r;
            e.tag = pt[p];
            if (d > 0) begin
               done_cyc = c + 1 + d;
               resp_cyc = c + 2 + d;
               dres     = fres(ic, ia, ib);
               dfl      = ffl(ic, ia, ib);
               e.res    = dres;
               e.fl     = dfl;
               e.to     = 1'b0;
            end else begin
               done_cyc = -10;
               resp_cyc = c + 2 + TO;
               e.res    = 32'h7FC0_0000;
               e.fl     = 5'b10000;
               e.to     = 1'b1;
            end
            e.cyc   = resp_cyc;
            free_at = resp_cyc + 1;
            q.push_back(e);
         end
      end

      check("queue_drained", 128'(q.size()), 128'(0));
      check("reset_exercised", 128'(rst_done), 128'(1));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
